// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-N demultiplexer: error counter width,
// saturation value and a saturating increment helper.
package demux_pkg;

  localparam int unsigned ErrCntW = 16;
  localparam logic [ErrCntW-1:0] ErrCntSat = 16'hFFFF;

  function automatic logic [ErrCntW-1:0] err_cnt_inc(input logic [ErrCntW-1:0] cnt);
    return (cnt == ErrCntSat) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry {val,msg} output buffer for a single demux channel, with
// simultaneous drain-and-reload support for full throughput.
module demux_chan_buf #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [NBITS-1:0] msg_i,
  input  logic             rdy_i,
  output logic             val_o,
  output logic [NBITS-1:0] msg_o,
  output logic             free_o
);

  logic             val_q, val_d;
  logic [NBITS-1:0] msg_q, msg_d;

  assign free_o = !val_q || rdy_i;
  assign val_o  = val_q;
  assign msg_o  = msg_q;

  // load_i is only raised while free_o is high, so a load may overwrite a draining entry
  always_comb begin
    val_d = val_q;
    msg_d = msg_q;
    if (load_i) begin
      val_d = 1'b1;
      msg_d = msg_i;
    end else if (val_q && rdy_i) begin
      val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= 1'b0;
      msg_q <= '0;
    end else begin
      val_q <= val_d;
      msg_q <= msg_d;
    end
  end

endmodule

// File: rtl/demux_1ton_buf.sv
// Buffered 1-to-NCH valid/ready demultiplexer with per-channel output registers.
// Define DEMUX_BCAST_EN to add the in_bcast port (load every channel at once).
module demux_1ton_buf
  import demux_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NCH   = 8,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [NBITS-1:0]     in_msg,
  input  logic [SELW-1:0]      in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                 in_bcast,
`endif
  output logic [NCH-1:0]       out_val,
  input  logic [NCH-1:0]       out_rdy,
  output logic [NCH*NBITS-1:0] out_msg,
  output logic [ErrCntW-1:0]   err_count
);

  logic                bcast;
  logic                sel_oob;
  logic                sel_free;
  logic                xfer;
  logic [NCH-1:0]      chan_free;
  logic [NCH-1:0]      chan_load;
  logic [ErrCntW-1:0]  err_q, err_d;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    sel_oob  = (32'(in_sel) >= NCH);
    sel_free = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_sel == SELW'(i)) sel_free = chan_free[i];
    end

    if (bcast) begin
      in_rdy = &chan_free;
    end else if (sel_oob) begin
      in_rdy = 1'b1;  // out-of-range messages are swallowed and counted
    end else begin
      in_rdy = sel_free;
    end

    xfer = in_val && in_rdy;
    for (int i = 0; i < NCH; i++) begin
      chan_load[i] = xfer && (bcast || (!sel_oob && (in_sel == SELW'(i))));
    end

    err_d = err_q;
    if (xfer && !bcast && sel_oob) err_d = err_cnt_inc(err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    demux_chan_buf #(
      .NBITS (NBITS)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .load_i (chan_load[g]),
      .msg_i  (in_msg),
      .rdy_i  (out_rdy[g]),
      .val_o  (out_val[g]),
      .msg_o  (out_msg[g*NBITS +: NBITS]),
      .free_o (chan_free[g])
    );
  end

endmodule

// File: tb/tb_demux_1ton_buf.sv
// Self-checking bench for demux_1ton_buf: scoreboard on an 8-channel instance plus
// a 5-channel instance for out-of-range drops and error-counter saturation.
module tb_demux_1ton_buf;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [7:0]  in_msg = '0;
  logic [2:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic [7:0]  out_val;
  logic [7:0]  out_rdy = 8'hFF;
  logic [63:0] out_msg;
  logic [15:0] err_count;

  logic        in5_val = 1'b0;
  logic        in5_rdy;
  logic [7:0]  in5_msg = '0;
  logic [2:0]  in5_sel = '0;
  logic [4:0]  out5_val;
  logic [4:0]  out5_rdy = 5'h1F;
  logic [39:0] out5_msg;
  logic [15:0] err5_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  byte_q_t    sb_q [8];
  logic [7:0] exp_val;
  logic       exp_rdy;
  logic [7:0] exp_msg;

  always #5 clk = ~clk;

  demux_1ton_buf #(
    .NBITS (8),
    .NCH   (8)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .err_count (err_count)
  );

  demux_1ton_buf #(
    .NBITS (8),
    .NCH   (5)
  ) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in5_val),
    .in_rdy    (in5_rdy),
    .in_msg    (in5_msg),
    .in_sel    (in5_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (1'b0),
`endif
    .out_val   (out5_val),
    .out_rdy   (out5_rdy),
    .out_msg   (out5_msg),
    .err_count (err5_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the 8-channel instance, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) sb_q[i].delete();
      end else begin
        for (int i = 0; i < 8; i++) exp_val[i] = (sb_q[i].size() != 0);
        check_eq("out_val", 64'(out_val), 64'(exp_val));
        if (in_bcast) exp_rdy = &(~exp_val | out_rdy);
        else          exp_rdy = !exp_val[in_sel] || out_rdy[in_sel];
        check_eq("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        for (int i = 0; i < 8; i++) begin
          if (out_val[i] && out_rdy[i] && sb_q[i].size() != 0) begin
            exp_msg = sb_q[i].pop_front();
            check_eq("out_msg", 64'(out_msg[i*8 +: 8]), 64'(exp_msg));
          end
        end
        if (in_val && exp_rdy) begin
          if (in_bcast) for (int i = 0; i < 8; i++) sb_q[i].push_back(in_msg);
          else          sb_q[in_sel].push_back(in_msg);
        end
      end
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_out_val", 64'(out_val), 64'h0);
    check_eq("rst_out_msg", out_msg, 64'h0);
    check_eq("rst_err", 64'(err_count), 64'h0);
    check_eq("rst_in_rdy", 64'(in_rdy), 64'h1);
    mon_en = 1'b1;

    // Single message, one-cycle latency
    in_val = 1'b1; in_msg = 8'hA5; in_sel = 3'd3; out_rdy = 8'hFF;
    step();
    in_val = 1'b0;
    check_eq("single_val", 64'(out_val), 64'h08);
    check_eq("single_msg", 64'(out_msg[3*8 +: 8]), 64'hA5);
    step();
    check_eq("single_drained", 64'(out_val), 64'h0);

    // Stalled channel blocks a second message until ready rises
    out_rdy = 8'hFB;
    in_val = 1'b1; in_msg = 8'h11; in_sel = 3'd2;
    step();
    in_msg = 8'h22;
    check_eq("stall_rdy0", 64'(in_rdy), 64'h0);
    step();
    check_eq("stall_hold", 64'(out_msg[2*8 +: 8]), 64'h11);
    out_rdy = 8'hFF;
    #1;
    check_eq("stall_release_rdy", 64'(in_rdy), 64'h1);
    step();
    in_val = 1'b0;
    check_eq("stall_second_val", 64'(out_val), 64'h04);
    check_eq("stall_second_msg", 64'(out_msg[2*8 +: 8]), 64'h22);
    step();

    // Streaming one message per cycle across all channels
    for (int k = 0; k < 8; k++) begin
      in_val = 1'b1; in_sel = 3'(k); in_msg = 8'(k * 17 + 3);
      #1;
      check_eq("stream_rdy", 64'(in_rdy), 64'h1);
      step();
      check_eq("stream_val", 64'(out_val), 64'(8'h01 << k));
      check_eq("stream_msg", 64'(out_msg[k*8 +: 8]), 64'(k * 17 + 3));
    end
    in_val = 1'b0;
    step();

    // Randomised traffic with random back-pressure
    for (int k = 0; k < 300; k++) begin
      in_val  = 1'($urandom_range(1));
      in_sel  = 3'($urandom_range(7));
      in_msg  = 8'($urandom);
      out_rdy = 8'($urandom);
      step();
    end
    in_val = 1'b0;
    out_rdy = 8'hFF;
    step();
    step();
    for (int i = 0; i < 8; i++) check_eq("sb_empty", 64'(sb_q[i].size()), 64'h0);

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every channel to be free
    out_rdy = 8'hEF;
    in_val = 1'b1; in_sel = 3'd4; in_msg = 8'h44;
    step();
    in_bcast = 1'b1; in_msg = 8'h99; in_sel = 3'd1;
    #1;
    check_eq("bcast_rdy0", 64'(in_rdy), 64'h0);
    step();
    out_rdy = 8'hFF;
    #1;
    check_eq("bcast_rdy1", 64'(in_rdy), 64'h1);
    step();
    in_val = 1'b0; in_bcast = 1'b0;
    check_eq("bcast_val", 64'(out_val), 64'hFF);
    check_eq("bcast_msg", out_msg, 64'h9999_9999_9999_9999);
    check_eq("bcast_err", 64'(err_count), 64'h0);
    step();
`endif

    // Out-of-range drops on the 5-channel instance
    for (int k = 0; k < 3; k++) begin
      in5_val = 1'b1; in5_sel = 3'd6; in5_msg = 8'(k);
      #1;
      check_eq("oob_rdy", 64'(in5_rdy), 64'h1);
      step();
      check_eq("oob_no_val", 64'(out5_val), 64'h0);
    end
    in5_val = 1'b0;
    check_eq("oob_err3", 64'(err5_count), 64'd3);
    in5_val = 1'b1; in5_sel = 3'd4; in5_msg = 8'h5C;
    step();
    in5_val = 1'b0;
    check_eq("ch4_val", 64'(out5_val), 64'h10);
    check_eq("ch4_msg", 64'(out5_msg[4*8 +: 8]), 64'h5C);
    check_eq("ch4_err", 64'(err5_count), 64'd3);
    in5_val = 1'b1; in5_sel = 3'd5;
    for (int k = 0; k < 65532; k++) step();
    check_eq("err_at_max", 64'(err5_count), 64'hFFFF);
    for (int k = 0; k < 3; k++) step();
    in5_val = 1'b0;
    check_eq("err_saturated", 64'(err5_count), 64'hFFFF);

    // Reset mid-operation with channels 1 and 6 full and a competing transfer
    out_rdy = 8'h00;
    in_val = 1'b1; in_sel = 3'd1; in_msg = 8'h61;
    step();
    in_sel = 3'd6; in_msg = 8'h66;
    step();
    check_eq("pre_rst_val", 64'(out_val), 64'h42);
    in_sel = 3'd0; in_msg = 8'h77;
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_val = 1'b0;
    check_eq("mid_rst_val", 64'(out_val), 64'h0);
    check_eq("mid_rst_msg", out_msg, 64'h0);
    check_eq("mid_rst_err", 64'(err_count), 64'h0);
    check_eq("mid_rst_err5", 64'(err5_count), 64'h0);
    out_rdy = 8'hFF;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
